// File: rtl/led_pattern_seq.sv
// Parametrised active-low LED pattern sequencer stepped from clk1h through a prescaler.
// Modes: rotate-right, rotate-left, ping-pong, binary count; wrap pulses once per pattern period.
module led_pattern_seq #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned STEP_DIV = 1
) (
  input  logic             clk1h,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             mode_ld,
  output logic [WIDTH-1:0] led,
  output logic             wrap,
  output logic             step
);

  localparam int unsigned PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PW-1:0] POS_MAX = PW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(STEP_DIV - 1);

  typedef enum logic [1:0] {
    M_ROR  = 2'd0,
    M_ROL  = 2'd1,
    M_PING = 2'd2,
    M_CNT  = 2'd3
  } mode_e;

  mode_e            r_mode, w_mode_nx;
  logic [PW-1:0]    r_pos,  w_pos_nx;
  logic             r_dir,  w_dir_nx;
  logic [WIDTH-1:0] r_cnt,  w_cnt_nx;
  logic [DW-1:0]    r_div,  w_div_nx;
  logic [WIDTH-1:0] r_led,  w_led_nx;
  logic             r_wrap, w_wrap_nx;
  logic             r_step, w_step_nx;
  logic             w_step_ev;

  assign led  = r_led;
  assign wrap = r_wrap;
  assign step = r_step;

  assign w_step_ev = en && (r_div == DIV_MAX);

  always_ff @(posedge clk1h or negedge rst) begin
    if (!rst) begin
      r_mode <= M_ROR;
      r_pos  <= '0;
      r_dir  <= 1'b1;
      r_cnt  <= '0;
      r_div  <= '0;
      r_led  <= ~(WIDTH'(1));
      r_wrap <= 1'b0;
      r_step <= 1'b0;
    end else begin
      r_mode <= w_mode_nx;
      r_pos  <= w_pos_nx;
      r_dir  <= w_dir_nx;
      r_cnt  <= w_cnt_nx;
      r_div  <= w_div_nx;
      r_led  <= w_led_nx;
      r_wrap <= w_wrap_nx;
      r_step <= w_step_nx;
    end
  end

  // mode_ld wins over any coincident step and ignores en
  always_comb begin
    w_mode_nx = r_mode;
    w_pos_nx  = r_pos;
    w_dir_nx  = r_dir;
    w_cnt_nx  = r_cnt;
    w_div_nx  = r_div;
    if (mode_ld) begin
      w_mode_nx = mode_e'(mode);
      w_pos_nx  = '0;
      w_dir_nx  = 1'b1;
      w_cnt_nx  = '0;
      w_div_nx  = '0;
    end else if (en) begin
      w_div_nx = w_step_ev ? '0 : r_div + DW'(1);
      if (w_step_ev) begin
        case (r_mode)
          M_ROR:  w_pos_nx = (r_pos == '0) ? POS_MAX : r_pos - PW'(1);
          M_ROL:  w_pos_nx = (r_pos == POS_MAX) ? '0 : r_pos + PW'(1);
          M_PING: begin
            // reversing at an end also moves inward, so end LEDs never repeat
            if (r_dir) begin
              if (r_pos == POS_MAX) begin
                w_pos_nx = r_pos - PW'(1);
                w_dir_nx = 1'b0;
              end else begin
                w_pos_nx = r_pos + PW'(1);
              end
            end else begin
              if (r_pos == '0) begin
                w_pos_nx = PW'(1);
                w_dir_nx = 1'b1;
              end else begin
                w_pos_nx = r_pos - PW'(1);
              end
            end
          end
          default: w_cnt_nx = r_cnt + WIDTH'(1);
        endcase
      end
    end
  end

  always_comb begin
    w_led_nx  = r_led;
    w_wrap_nx = 1'b0;
    w_step_nx = 1'b0;
    if (mode_ld) begin
      w_led_nx = (mode_e'(mode) == M_CNT) ? '1 : ~(WIDTH'(1));
    end else if (w_step_ev) begin
      w_step_nx = 1'b1;
      w_led_nx  = (r_mode == M_CNT) ? ~w_cnt_nx : ~(WIDTH'(1) << w_pos_nx);
      case (r_mode)
        M_ROR:   w_wrap_nx = (r_pos == '0);
        M_ROL:   w_wrap_nx = (r_pos == POS_MAX);
        M_PING:  w_wrap_nx = (w_pos_nx == '0);
        default: w_wrap_nx = (r_cnt == '1);
      endcase
    end
  end

endmodule

// File: tb/tb_led_pattern_seq.sv
// Bench for led_pattern_seq: three instances (8/1, 8/3, 4/1) against a step-count reference model.
module tb_led_pattern_seq;

  logic clk1h = 1'b0;
  always #5 clk1h = ~clk1h;

  logic            rst;
  logic [2:0]      en_v, ld_v;
  logic [2:0][1:0] mode_v;
  logic [7:0]      led_a, led_b;
  logic [3:0]      led_c;
  logic [2:0]      wrap_v, step_v;

  int   W  [3] = '{8, 8, 4};
  int   SD [3] = '{1, 3, 1};
  int   m_mode [3];
  int   m_k    [3];
  int   m_div  [3];
  logic m_wrap [3];
  logic m_step [3];
  int   checks = 0;
  int   passed = 0;

  led_pattern_seq #(.WIDTH(8), .STEP_DIV(1)) u0 (
    .clk1h(clk1h), .rst(rst), .en(en_v[0]), .mode(mode_v[0]), .mode_ld(ld_v[0]),
    .led(led_a), .wrap(wrap_v[0]), .step(step_v[0]));

  led_pattern_seq #(.WIDTH(8), .STEP_DIV(3)) u1 (
    .clk1h(clk1h), .rst(rst), .en(en_v[1]), .mode(mode_v[1]), .mode_ld(ld_v[1]),
    .led(led_b), .wrap(wrap_v[1]), .step(step_v[1]));

  led_pattern_seq #(.WIDTH(4), .STEP_DIV(1)) u2 (
    .clk1h(clk1h), .rst(rst), .en(en_v[2]), .mode(mode_v[2]), .mode_ld(ld_v[2]),
    .led(led_c), .wrap(wrap_v[2]), .step(step_v[2]));

  // Pattern as a function of steps taken since the last restart.
  function automatic logic [7:0] exp_led(int md, int k, int w);
    int mask, p, per, r;
    mask = (1 << w) - 1;
    case (md)
      0: p = (w - (k % w)) % w;
      1: p = k % w;
      2: begin
        per = 2 * (w - 1);
        r   = k % per;
        p   = (r < w) ? r : per - r;
      end
      default: return 8'((~(k % (1 << w))) & mask);
    endcase
    return 8'((~(1 << p)) & mask);
  endfunction

  function automatic logic exp_wrap(int md, int k, int w);
    case (md)
      0:       return (k % w) == 1;
      1:       return (k % w) == 0;
      2:       return (k % (2 * (w - 1))) == 0;
      default: return (k % (1 << w)) == 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_mode[i] = 0; m_k[i] = 0; m_div[i] = 0;
      m_wrap[i] = 1'b0; m_step[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      m_wrap[i] = 1'b0;
      m_step[i] = 1'b0;
      if (!rst) begin
        m_mode[i] = 0; m_k[i] = 0; m_div[i] = 0;
      end else if (ld_v[i]) begin
        m_mode[i] = int'(mode_v[i]); m_k[i] = 0; m_div[i] = 0;
      end else if (en_v[i]) begin
        if (m_div[i] == SD[i] - 1) begin
          m_div[i]  = 0;
          m_k[i]    = m_k[i] + 1;
          m_step[i] = 1'b1;
          m_wrap[i] = exp_wrap(m_mode[i], m_k[i], W[i]);
        end else begin
          m_div[i] = m_div[i] + 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input int i, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s[%0d] observed=%h expected=%h", tag, i, obs, exp);
  endtask

  task automatic check_all(input string tag);
    logic [7:0] obs;
    for (int i = 0; i < 3; i++) begin
      obs = (i == 0) ? led_a : (i == 1) ? led_b : {4'h0, led_c};
      chk({tag, "_led"}, i, obs, exp_led(m_mode[i], m_k[i], W[i]));
      chk({tag, "_wrap"}, i, {7'b0, wrap_v[i]}, {7'b0, m_wrap[i]});
      chk({tag, "_step"}, i, {7'b0, step_v[i]}, {7'b0, m_step[i]});
    end
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk1h);
    #1;
    check_all(tag);
  endtask

  task automatic run(input int n, input string tag);
    repeat (n) tick(tag);
  endtask

  initial begin
    en_v = '0; ld_v = '0; mode_v = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    model_reset();
    #11 check_all("reset");
    rst = 1'b1;

    // rotate right, every cycle a step
    en_v[0] = 1'b1;
    run(9, "t1");
    en_v[0] = 1'b0;

    // rotate left with prescaler 3, including a frozen stretch
    mode_v[1] = 2'd1; ld_v[1] = 1'b1;
    tick("t2ld");
    ld_v[1] = 1'b0; en_v[1] = 1'b1;
    run(7, "t2");
    en_v[1] = 1'b0;
    run(5, "t2hold");
    en_v[1] = 1'b1;
    run(6, "t2");
    en_v[1] = 1'b0;

    // ping-pong then binary count on the 4-wide instance
    mode_v[2] = 2'd2; ld_v[2] = 1'b1;
    tick("t3ld");
    ld_v[2] = 1'b0; en_v[2] = 1'b1;
    run(8, "t3");
    mode_v[2] = 2'd3; ld_v[2] = 1'b1;
    tick("t4ld");
    ld_v[2] = 1'b0;
    run(17, "t4");
    en_v[2] = 1'b0;

    // mode load coincident with a step at pos 5
    mode_v[0] = 2'd0; ld_v[0] = 1'b1;
    tick("t5ld0");
    ld_v[0] = 1'b0; en_v[0] = 1'b1;
    run(3, "t5rot");
    mode_v[0] = 2'd2; ld_v[0] = 1'b1;
    tick("t5ld2");
    ld_v[0] = 1'b0;
    run(6, "t5ping");
    en_v[0] = 1'b0;

    // asynchronous reset mid prescale count
    mode_v[1] = 2'd1; ld_v[1] = 1'b1;
    tick("t6ld");
    ld_v[1] = 1'b0; en_v[1] = 1'b1;
    run(4, "t6pre");
    #2 rst = 1'b0;
    model_reset();
    #1 check_all("t6async");
    tick("t6held");
    rst = 1'b1;
    run(5, "t6post");

    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 3; i++) begin
        en_v[i]   = ($urandom_range(0, 3) != 0);
        ld_v[i]   = ($urandom_range(0, 15) == 0);
        mode_v[i] = 2'($urandom_range(0, 3));
      end
      tick("rand");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
